rvfi_trace_buffer: RTL

- Sits directly downstream of the core's RVFI retirement outputs and consumes one retired-instruction record per cycle.
- Stamps each record with a retirement order number and buffers it in a FIFO.
- Drains records over a valid/ready stream to a trace sink (bench logger or debug link).
- Raises a stall request toward the core when nearly full; flags overflow if records are dropped.

---
 rtl/rvfi_trace_buffer_if.sv | 24 ++
 rtl/rvfi_trace_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_buffer_if.sv
// Trace stream between rvfi_trace_buffer and a trace sink (logger or debug link).
// The master presents the head retirement record; the slave accepts it with ready.
interface rvfi_trace_buffer_if;
    logic        valid;
    logic        ready;
    logic [31:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;

    modport master (
        output valid, order, pc, insn, rd_addr, rd_wdata, mem_addr, mem_wmask, mem_wdata,
        input  ready
    );

    modport slave (
        input  valid, order, pc, insn, rd_addr, rd_wdata, mem_addr, mem_wmask, mem_wdata,
        output ready
    );
endinterface

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: stamps each retired instruction with an order number,
// queues it in a FIFO and drains it over a valid/ready stream. Requests a core stall when
// nearly full and flags sticky overflow when a record is dropped.
// Optional PC continuity checker enabled by defining TRACE_PC_CHECK_EN.
module rvfi_trace_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rvfi_i_valid,
    input  logic [31:0]              rvfi_i_insn,
    input  logic [31:0]              rvfi_i_pc_rdata,
    input  logic [31:0]              rvfi_i_pc_wdata,
    input  logic [4:0]               rvfi_i_rd_addr,
    input  logic [31:0]              rvfi_i_rd_wdata,
    input  logic [31:0]              rvfi_i_mem_addr,
    input  logic [3:0]               rvfi_i_mem_wmask,
    input  logic [31:0]              rvfi_i_mem_wdata,
    rvfi_trace_buffer_if.master      trace,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     core_stall_req_o,
    output logic                     overflow_o,
    output logic                     pc_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    typedef struct packed {
        logic [31:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } rec_t;

    rec_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_order;
    logic          r_overflow;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    rec_t w_rec;
    rec_t w_head;

    // Handshake decode and the record to be enqueued this cycle.
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == FULL_CNT);
        w_pop   = w_valid && trace.ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        w_push  = rvfi_i_valid && (!w_full || w_pop);
        w_drop  = rvfi_i_valid && w_full && !w_pop;

        w_rec           = '0;
        w_rec.order     = r_order;
        w_rec.pc        = rvfi_i_pc_rdata;
        w_rec.insn      = rvfi_i_insn;
        w_rec.rd_addr   = rvfi_i_rd_addr;
        // x0 writes are architecturally discarded; do not leak the core's bus value.
        w_rec.rd_wdata  = (rvfi_i_rd_addr == 5'd0) ? 32'h0 : rvfi_i_rd_wdata;
        w_rec.mem_addr  = rvfi_i_mem_addr;
        w_rec.mem_wmask = rvfi_i_mem_wmask;
        w_rec.mem_wdata = rvfi_i_mem_wdata;
    end

    // Record storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    // Pointers, occupancy, order counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_order    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Counts dropped records too, so drops show up as gaps in the order stream.
            if (rvfi_i_valid) begin
                r_order <= r_order + 32'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head record from storage, forced to zero while empty so reset shows all-zero outputs.
    always_comb begin
        w_head          = w_valid ? r_mem[r_rd_ptr] : '0;
        trace.valid     = w_valid;
        trace.order     = w_head.order;
        trace.pc        = w_head.pc;
        trace.insn      = w_head.insn;
        trace.rd_addr   = w_head.rd_addr;
        trace.rd_wdata  = w_head.rd_wdata;
        trace.mem_addr  = w_head.mem_addr;
        trace.mem_wmask = w_head.mem_wmask;
        trace.mem_wdata = w_head.mem_wdata;
    end

    // Status outputs depend on registered state only.
    always_comb begin
        count_o          = r_count;
        core_stall_req_o = (r_count >= AFULL_CNT);
        overflow_o       = r_overflow;
    end

`ifdef TRACE_PC_CHECK_EN
    logic [31:0] r_prev_pc_wdata;
    logic        r_first_seen;
    logic        r_pc_err;

    // Each retirement must start where the previous one said the PC would go next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_pc_wdata <= '0;
            r_first_seen    <= 1'b0;
            r_pc_err        <= 1'b0;
        end else if (rvfi_i_valid) begin
            if (r_first_seen && (rvfi_i_pc_rdata != r_prev_pc_wdata)) begin
                r_pc_err <= 1'b1;
            end
            r_prev_pc_wdata <= rvfi_i_pc_wdata;
            r_first_seen    <= 1'b1;
        end
    end

    assign pc_err_o = r_pc_err;
`else
    logic w_unused_pc_wdata;

    assign w_unused_pc_wdata = ^rvfi_i_pc_wdata;
    assign pc_err_o          = 1'b0;
`endif

endmodule
